// File: rtl/bit_stream_serializer_if.sv
// Load-side valid/ready handshake for bit_stream_serializer.
// The master drives words in and the slave accepts them.
interface bit_stream_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] Load_Data;
  logic             Load_Valid;
  logic             Load_Ready;

  modport master (
    output Load_Data,
    output Load_Valid,
    input  Load_Ready
  );

  modport slave (
    input  Load_Data,
    input  Load_Valid,
    output Load_Ready
  );
endinterface

// File: rtl/bit_stream_serializer.sv
// Parallel-in serial-out stage feeding the Moore sequence detector.
// Define SER_PARITY_EN to append an even-parity bit after each word.
module bit_stream_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  bit_stream_serializer_if.slave load,
  output logic                  Dout,
  output logic                  Dout_Valid,
  output logic                  Busy,
  output logic                  Word_Done
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_dout;
  logic             w_dout_nxt;
  logic             w_last_data;
  logic             w_final;
  logic             w_ready;
  logic             w_accept;
`ifdef SER_PARITY_EN
  logic             r_par;
  logic             w_par_nxt;
`endif

  function automatic logic f_head(
    input logic [WIDTH-1:0] v
  );
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] f_advance(
    input logic [WIDTH-1:0] v
  );
    if (MSB_FIRST)
      return {v[WIDTH-2:0], 1'b0};
    return {1'b0, v[WIDTH-1:1]};
  endfunction

  assign w_last_data = (r_state == S_SHIFT)
                    && (r_cnt == LAST);

`ifdef SER_PARITY_EN
  assign w_final = (r_state == S_PARITY);
`else
  assign w_final = w_last_data;
`endif

  assign w_ready  = (r_state == S_IDLE) || w_final;
  assign w_accept = load.Load_Valid && w_ready;

  // State register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_last_data) begin
`ifdef SER_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = w_accept ? S_SHIFT : S_IDLE;
`endif
        end
      end
      S_PARITY: begin
        w_state_nxt = w_accept ? S_SHIFT : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath next values; accept and mid-word shift never overlap
  always_comb begin
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    unique case (1'b1)
      w_accept: begin
        w_shift_nxt = load.Load_Data;
        w_cnt_nxt   = '0;
      end
      ((r_state == S_SHIFT) && !w_last_data): begin
        w_shift_nxt = f_advance(r_shift);
        w_cnt_nxt   = r_cnt + CW'(1);
      end
      default: begin
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef SER_PARITY_EN
  assign w_par_nxt = w_accept ? ^load.Load_Data : r_par;
`endif

  // Dout is the bit that will be on the wire after the coming edge
  always_comb begin
    w_dout_nxt = IDLE_LEVEL;
    unique case (w_state_nxt)
      S_SHIFT:  w_dout_nxt = f_head(w_shift_nxt);
`ifdef SER_PARITY_EN
      S_PARITY: w_dout_nxt = r_par;
`endif
      default:  w_dout_nxt = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_dout  <= IDLE_LEVEL;
    end else begin
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dout  <= w_dout_nxt;
    end
  end

`ifdef SER_PARITY_EN
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)
      r_par <= 1'b0;
    else
      r_par <= w_par_nxt;
  end
`endif

  // Output logic
  always_comb begin
    load.Load_Ready = w_ready;
    Busy            = (r_state != S_IDLE);
    Dout_Valid      = (r_state != S_IDLE);
    Word_Done       = w_final;
    Dout            = r_dout;
  end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Directed bench for bit_stream_serializer, WIDTH=4.
// Runs an MSB-first and an LSB-first instance side by side.
module tb_bit_stream_serializer;

  localparam int W = 4;
`ifdef SER_PARITY_EN
  localparam int LEN = W + 1;
`else
  localparam int LEN = W;
`endif

  typedef struct {
    logic [3:0] data;
    logic [3:0] msb;
    logic [3:0] lsb;
    logic       par;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit_stream_serializer_if #(.WIDTH(W)) if_m ();
  bit_stream_serializer_if #(.WIDTH(W)) if_l ();

  logic m_dout, m_dv, m_busy, m_wd;
  logic l_dout, l_dv, l_busy, l_wd;

  bit_stream_serializer #(
    .WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)
  ) u_msb (
    .Clock(clk), .Reset_n(rst_n), .load(if_m.slave),
    .Dout(m_dout), .Dout_Valid(m_dv),
    .Busy(m_busy), .Word_Done(m_wd)
  );

  bit_stream_serializer #(
    .WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)
  ) u_lsb (
    .Clock(clk), .Reset_n(rst_n), .load(if_l.slave),
    .Dout(l_dout), .Dout_Valid(l_dv),
    .Busy(l_busy), .Word_Done(l_wd)
  );

  int n_chk  = 0;
  int n_pass = 0;
  vec_t tbl[6];

  task automatic chk(input string name, input logic act,
                     input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] d);
    if_m.Load_Valid = v;
    if_m.Load_Data  = d;
    if_l.Load_Valid = v;
    if_l.Load_Data  = d;
  endtask

  function automatic logic exp_bit(input vec_t v, input int i,
                                   input bit msb);
    if (i >= W) return v.par;
    return msb ? v.msb[W-1-i] : v.lsb[W-1-i];
  endfunction

  task automatic check_bit(input string tag, input logic em,
                           input logic el, input logic last);
    chk({tag, " dout_m"}, m_dout, em);
    chk({tag, " dout_l"}, l_dout, el);
    chk({tag, " valid"}, m_dv, 1'b1);
    chk({tag, " busy"}, m_busy, 1'b1);
    chk({tag, " done_m"}, m_wd, last);
    chk({tag, " done_l"}, l_wd, last);
    chk({tag, " ready"}, if_m.Load_Ready, last);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " idle_valid"}, m_dv, 1'b0);
    chk({tag, " idle_dout"}, m_dout, 1'b0);
    chk({tag, " idle_busy"}, m_busy, 1'b0);
    chk({tag, " idle_done"}, m_wd, 1'b0);
    chk({tag, " idle_ready"}, if_m.Load_Ready, 1'b1);
    chk({tag, " idle_valid_l"}, l_dv, 1'b0);
    chk({tag, " idle_busy_l"}, l_busy, 1'b0);
  endtask

  // Called at a negedge while idle; accepts on the next posedge
  task automatic run_word(input vec_t v, input string tag);
    drive(1'b1, v.data);
    @(posedge clk);
    #1 drive(1'b0, 4'h0);
    for (int i = 0; i < LEN; i++) begin
      @(negedge clk);
      check_bit($sformatf("%s b%0d", tag, i),
                exp_bit(v, i, 1'b1), exp_bit(v, i, 1'b0),
                i == LEN - 1);
    end
    @(negedge clk);
    check_idle(tag);
  endtask

  initial begin
    tbl[0] = '{4'b1101, 4'b1101, 4'b1011, 1'b1};
    tbl[1] = '{4'b0110, 4'b0110, 4'b0110, 1'b0};
    tbl[2] = '{4'b1000, 4'b1000, 4'b0001, 1'b1};
    tbl[3] = '{4'b0111, 4'b0111, 4'b1110, 1'b1};
    tbl[4] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[5] = '{4'b1011, 4'b1011, 4'b1101, 1'b1};

    drive(1'b0, 4'h0);
    #2;
    chk("rst dout", m_dout, 1'b0);
    chk("rst valid", m_dv, 1'b0);
    chk("rst busy", m_busy, 1'b0);
    chk("rst done", m_wd, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_rst");

    for (int t = 0; t < 6; t++)
      run_word(tbl[t], $sformatf("vec%0d", t));

    // Back-to-back: second word accepted on the final bit
    drive(1'b1, tbl[0].data);
    @(posedge clk);
    #1 drive(1'b1, tbl[5].data);
    for (int i = 0; i < 2 * LEN; i++) begin
      @(negedge clk);
      if (i < LEN)
        check_bit($sformatf("b2b b%0d", i),
                  exp_bit(tbl[0], i, 1'b1),
                  exp_bit(tbl[0], i, 1'b0), i == LEN - 1);
      else
        check_bit($sformatf("b2b b%0d", i),
                  exp_bit(tbl[5], i - LEN, 1'b1),
                  exp_bit(tbl[5], i - LEN, 1'b0),
                  i == 2 * LEN - 1);
      if (i == LEN - 1) begin
        @(posedge clk);
        #1 drive(1'b0, 4'h0);
      end
    end
    @(negedge clk);
    check_idle("b2b");

    // Valid held with changing data mid-word
    drive(1'b1, tbl[0].data);
    @(posedge clk);
    #1 drive(1'b1, 4'h0);
    for (int i = 0; i < LEN; i++) begin
      @(negedge clk);
      check_bit($sformatf("hold b%0d", i),
                exp_bit(tbl[0], i, 1'b1),
                exp_bit(tbl[0], i, 1'b0), i == LEN - 1);
      if (i < LEN - 1) begin
        @(posedge clk);
        #1 drive(i < LEN - 2, 4'(i * 5 + 6));
      end
    end
    @(negedge clk);
    check_idle("hold");

    // Reset while bit 2 is on Dout
    drive(1'b1, tbl[3].data);
    @(posedge clk);
    #1 drive(1'b0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_bit($sformatf("rstmid b%0d", i),
                exp_bit(tbl[3], i, 1'b1),
                exp_bit(tbl[3], i, 1'b0), 1'b0);
    end
    rst_n = 1'b0;
    drive(1'b1, 4'b1111);
    #1;
    chk("rstmid dout", m_dout, 1'b0);
    chk("rstmid dout_l", l_dout, 1'b0);
    chk("rstmid valid", m_dv, 1'b0);
    chk("rstmid busy", m_busy, 1'b0);
    chk("rstmid done", m_wd, 1'b0);
    @(posedge clk);
    #1;
    chk("rstmid ign_busy", m_busy, 1'b0);
    chk("rstmid ign_valid", m_dv, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, 4'h0);
    @(negedge clk);
    check_idle("rstmid rel");
    run_word(tbl[1], "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
